// File: rtl/uart_pkg.sv
// Definitions shared by the UART transmitter and receiver: state encoding,
// default frame geometry and a constant-width helper.
package uart_pkg;

  localparam int OS_RATE_DEF = 16;
  localparam int DATA_W_DEF  = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

  // Ceiling log2; returns 0 for n <= 1, so callers clamp to 1 where a width is needed.
  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Word handshake into the UART transmitter: the producer drives data/valid,
// the transmitter answers with ready when its holding register is free.
interface uart_tx_if #(
  parameter int DATA_W = 8
) ();

  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;

  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready
  );

endinterface

// File: rtl/uart_tx.sv
// UART transmitter: one-entry holding register feeding an MSB-first frame
// serialiser timed by the shared oversampling baud_tick strobe.
module uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int OS_RATE   = OS_RATE_DEF,
  parameter int STOP_BITS = 1
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     baud_tick,
  uart_tx_if.slave bus,
  output logic     tx,
  output logic     tx_busy,
  output logic     tx_done
);

  localparam int CNT_W = (clog2(OS_RATE * STOP_BITS) < 1) ? 1 : clog2(OS_RATE * STOP_BITS);
  localparam int BIT_W = (clog2(DATA_W) < 1) ? 1 : clog2(DATA_W);

  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(OS_RATE - 1);
  localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(OS_RATE * STOP_BITS - 1);
  localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_W - 1);

  logic [DATA_W-1:0] hold_p0;
  logic              vld_p0;
  logic              vld_p0_nxt;
  logic              accept;
  logic              load;

  uart_state_t       state_p1;
  uart_state_t       state_p1_nxt;
  logic [DATA_W-1:0] shift_p1;
  logic [DATA_W-1:0] shift_p1_nxt;
  logic [CNT_W-1:0]  tick_cnt;
  logic [CNT_W-1:0]  tick_cnt_nxt;
  logic [BIT_W-1:0]  bit_cnt;
  logic [BIT_W-1:0]  bit_cnt_nxt;
  logic              tx_nxt;
  logic              done_nxt;

  assign accept       = bus.tx_valid && !vld_p0;
  assign bus.tx_ready = !vld_p0;
  assign tx_busy      = (state_p1 != IDLE);

  // Stage p0 -> p1: the holding register is freed on the same edge the frame starts.
  always_comb begin
    state_p1_nxt = state_p1;
    shift_p1_nxt = shift_p1;
    tick_cnt_nxt = tick_cnt;
    bit_cnt_nxt  = bit_cnt;
    tx_nxt       = tx;
    done_nxt     = 1'b0;
    load         = 1'b0;

    unique case (state_p1)
      IDLE: begin
        tx_nxt = 1'b1;
        if (vld_p0) begin
          load         = 1'b1;
          shift_p1_nxt = hold_p0;
          tick_cnt_nxt = '0;
          bit_cnt_nxt  = '0;
          tx_nxt       = 1'b0;
          state_p1_nxt = START;
        end
      end

      START: begin
        if (baud_tick) begin
          if (tick_cnt == BIT_LAST) begin
            tick_cnt_nxt = '0;
            bit_cnt_nxt  = '0;
            tx_nxt       = shift_p1[DATA_W-1];
            shift_p1_nxt = shift_p1 << 1;
            state_p1_nxt = DATA;
          end else begin
            tick_cnt_nxt = tick_cnt + 1'b1;
          end
        end
      end

      DATA: begin
        if (baud_tick) begin
          if (tick_cnt == BIT_LAST) begin
            tick_cnt_nxt = '0;
            if (bit_cnt == DATA_LAST) begin
              tx_nxt       = 1'b1;
              state_p1_nxt = STOP;
            end else begin
              bit_cnt_nxt  = bit_cnt + 1'b1;
              tx_nxt       = shift_p1[DATA_W-1];
              shift_p1_nxt = shift_p1 << 1;
            end
          end else begin
            tick_cnt_nxt = tick_cnt + 1'b1;
          end
        end
      end

      STOP: begin
        if (baud_tick) begin
          if (tick_cnt == STOP_LAST) begin
            tick_cnt_nxt = '0;
            done_nxt     = 1'b1;
            state_p1_nxt = IDLE;
          end else begin
            tick_cnt_nxt = tick_cnt + 1'b1;
          end
        end
      end

      default: state_p1_nxt = IDLE;
    endcase

    vld_p0_nxt = vld_p0;
    if (load) begin
      vld_p0_nxt = 1'b0;
    end else if (accept) begin
      vld_p0_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_p1 <= IDLE;
      tick_cnt <= '0;
      bit_cnt  <= '0;
      tx       <= 1'b1;
      tx_done  <= 1'b0;
      vld_p0   <= 1'b0;
    end else begin
      state_p1 <= state_p1_nxt;
      tick_cnt <= tick_cnt_nxt;
      bit_cnt  <= bit_cnt_nxt;
      tx       <= tx_nxt;
      tx_done  <= done_nxt;
      vld_p0   <= vld_p0_nxt;
    end
  end

  // Data registers carry no reset; vld_p0 and the FSM state qualify them.
  always_ff @(posedge clk) begin
    if (accept) begin
      hold_p0 <= bus.tx_data;
    end
    shift_p1 <= shift_p1_nxt;
  end

endmodule
